// File: rtl/vdp_register_write_arbiter.sv
// Arbitrates VDP register-file writes between a queued CPU host path and the copper.
// Copper normally wins; a burst limit guarantees queued host writes eventually drain.
module vdp_register_write_arbiter #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned MAX_COP_BURST = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        host_write_en,
  input  logic [4:0]                  host_address,
  input  logic [15:0]                 host_write_data,
  output logic                        host_ready,
  input  logic                        cop_write_en,
  input  logic [4:0]                  cop_write_address,
  input  logic [15:0]                 cop_write_data,
  output logic                        cop_stall,
  input  logic                        vram_write_pending,
  output logic                        register_write_en,
  output logic [4:0]                  register_write_address,
  output logic [15:0]                 register_write_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW   = PtrW + 1;
  localparam int unsigned BurstW = $clog2(MAX_COP_BURST + 1);

  typedef enum logic [1:0] {GntNone, GntCop, GntHost} grant_e;

  logic [20:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]    level_q, level_d;
  logic [BurstW-1:0]  burst_q, burst_d;
  logic               host_ready_q;
  logic               we_q;
  logic [4:0]         addr_q;
  logic [15:0]        data_q;
  logic [20:0]        head;
  grant_e             grant;
  logic               fifo_empty, fifo_full, burst_max, push, pop;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LvlW'(FIFO_DEPTH));
    burst_max  = (burst_q == BurstW'(MAX_COP_BURST));
    // No bypass: fullness is judged at cycle start, and host_ready blocks a double push.
    push       = host_write_en && !fifo_full && !host_ready_q;

    grant = GntNone;
    if (!reset && !vram_write_pending) begin
      if (cop_write_en && !(!fifo_empty && burst_max)) begin
        grant = GntCop;
      end else if (!fifo_empty) begin
        grant = GntHost;
      end
    end
    pop = (grant == GntHost);

    level_d = level_q + LvlW'(push) - LvlW'(pop);

    burst_d = burst_q;
    if (pop || fifo_empty) begin
      burst_d = '0;
    end else if (grant == GntCop && !burst_max) begin
      burst_d = burst_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      burst_q      <= '0;
      host_ready_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q      <= level_d;
      burst_q      <= burst_d;
      host_ready_q <= push;
      we_q         <= (grant != GntNone);
      if (grant == GntCop) begin
        addr_q <= cop_write_address;
        data_q <= cop_write_data;
      end else if (grant == GntHost) begin
        addr_q <= head[20:16];
        data_q <= head[15:0];
      end
    end
  end

  // Storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {host_address, host_write_data};
  end

  assign cop_stall              = cop_write_en && (grant != GntCop);
  assign host_ready             = host_ready_q;
  assign register_write_en      = we_q;
  assign register_write_address = addr_q;
  assign register_write_data    = data_q;
  assign fifo_level             = level_q;

endmodule

// File: tb/tb_vdp_register_write_arbiter.sv
// Randomised and directed bench for vdp_register_write_arbiter against a queue-based model.
module tb_vdp_register_write_arbiter;

  localparam int FifoDepth = 4;
  localparam int MaxBurst  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_write_en = 1'b0;
  logic [4:0]  host_address = '0;
  logic [15:0] host_write_data = '0;
  logic        host_ready;
  logic        cop_write_en = 1'b0;
  logic [4:0]  cop_write_address = '0;
  logic [15:0] cop_write_data = '0;
  logic        cop_stall;
  logic        vram_write_pending = 1'b0;
  logic        register_write_en;
  logic [4:0]  register_write_address;
  logic [15:0] register_write_data;
  logic [2:0]  fifo_level;

  vdp_register_write_arbiter #(
    .FIFO_DEPTH   (FifoDepth),
    .MAX_COP_BURST(MaxBurst)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .host_write_en         (host_write_en),
    .host_address          (host_address),
    .host_write_data       (host_write_data),
    .host_ready            (host_ready),
    .cop_write_en          (cop_write_en),
    .cop_write_address     (cop_write_address),
    .cop_write_data        (cop_write_data),
    .cop_stall             (cop_stall),
    .vram_write_pending    (vram_write_pending),
    .register_write_en     (register_write_en),
    .register_write_address(register_write_address),
    .register_write_data   (register_write_data),
    .fifo_level            (fifo_level)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [20:0] q[$];
  int          burst;
  bit          exp_ready, exp_we, last_stall;
  logic [4:0]  exp_addr;
  logic [15:0] exp_data;

  int n_cmp = 0;
  int n_err = 0;

  int mode, sc, p_host, p_cop, p_vram;
  int seq;
  int cop_cnt, stall_cnt, prev_lvl;
  bit host_seen, first_seen;
  logic [4:0] first_addr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    burst      = 0;
    exp_ready  = 0;
    exp_we     = 0;
    exp_addr   = '0;
    exp_data   = '0;
    last_stall = 0;
  endtask

  task automatic drive();
    int lim;
    case (mode)
      0: begin
        if (!(host_write_en && !exp_ready)) begin
          host_write_en   = $urandom_range(99) < p_host;
          host_address    = 5'($urandom);
          host_write_data = 16'($urandom);
        end
        if (!(cop_write_en && last_stall)) begin
          cop_write_en      = $urandom_range(99) < p_cop;
          cop_write_address = 5'($urandom);
          cop_write_data    = 16'($urandom);
        end
        vram_write_pending = $urandom_range(99) < p_vram;
      end
      1, 2, 4: begin
        if (sc == 0) begin
          host_write_en   = 1'b1;
          host_address    = (mode == 4) ? 5'd5 : 5'd9;
          host_write_data = (mode == 4) ? 16'h1234 : 16'hbeef;
        end else if (exp_ready) begin
          host_write_en = 1'b0;
        end
        cop_write_en       = (mode != 4);
        cop_write_address  = 5'd3;
        cop_write_data     = 16'h0c0c;
        vram_write_pending = (mode == 2 && sc < 4);
      end
      3, 5: begin
        lim = (mode == 3) ? 6 : 3;
        if (!host_write_en || exp_ready) begin
          if (seq < lim) begin
            host_write_en   = 1'b1;
            host_address    = 5'(seq + 16);
            host_write_data = 16'($urandom);
            seq++;
          end else begin
            host_write_en = 1'b0;
          end
        end
        cop_write_en       = 1'b0;
        vram_write_pending = (mode == 5) || (sc < 12);
      end
      default: begin
        host_write_en      = 1'b0;
        cop_write_en       = 1'b0;
        vram_write_pending = 1'b0;
      end
    endcase
  endtask

  task automatic cycle();
    bit gc, gh, ne, push;
    logic [20:0] e;
    @(negedge clk);
    drive();
    #1;
    ne = q.size() != 0;
    gc = 0;
    gh = 0;
    if (!vram_write_pending) begin
      if (cop_write_en && !(ne && burst == MaxBurst)) gc = 1;
      else if (ne) gh = 1;
    end
    check_val("cop_stall", cop_stall, cop_write_en && !gc);
    check_val("reg_we", register_write_en, exp_we);
    check_val("reg_addr", register_write_address, exp_addr);
    check_val("reg_data", register_write_data, exp_data);
    check_val("host_ready", host_ready, exp_ready);
    check_val("fifo_level", fifo_level, q.size());

    if (mode == 4 && sc == 1) check_val("t34_ready_c1", host_ready, 1);
    if (mode == 4 && sc == 2) begin
      check_val("t34_we_c2", register_write_en, 1);
      check_val("t34_addr_c2", register_write_address, 5);
      check_val("t34_data_c2", register_write_data, 16'h1234);
    end
    if (mode == 1) begin
      if (register_write_en && !host_seen) begin
        if (register_write_address == 5'd9) host_seen = 1;
        else if (prev_lvl != 0) cop_cnt++;
      end
      if (cop_stall) stall_cnt++;
      prev_lvl = int'(fifo_level);
    end
    if (mode == 2 && register_write_en && !first_seen) begin
      first_seen = 1;
      first_addr = register_write_address;
    end

    @(posedge clk);
    push = host_write_en && (q.size() != FifoDepth) && !exp_ready;
    if (gh) begin
      e        = q.pop_front();
      exp_we   = 1;
      exp_addr = e[20:16];
      exp_data = e[15:0];
    end else if (gc) begin
      exp_we   = 1;
      exp_addr = cop_write_address;
      exp_data = cop_write_data;
    end else begin
      exp_we = 0;
    end
    if (gc && ne) burst = (burst < MaxBurst) ? burst + 1 : MaxBurst;
    else if (gh || !ne) burst = 0;
    if (push) q.push_back({host_address, host_write_data});
    exp_ready  = push;
    last_stall = cop_write_en && !gc;
    sc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset              = 1'b1;
    host_write_en      = 1'b0;
    cop_write_en       = 1'b0;
    vram_write_pending = 1'b0;
    #1;
    check_val("rst_level", fifo_level, 0);
    check_val("rst_we", register_write_en, 0);
    check_val("rst_addr", register_write_address, 0);
    check_val("rst_data", register_write_data, 0);
    check_val("rst_ready", host_ready, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    cop_write_en = 1'b1;
    #1;
    check_val("rst_cop_stall", cop_stall, 1);
    cop_write_en = 1'b0;
    reset        = 1'b0;
  endtask

  task automatic run(input int m, input int n);
    mode = m;
    sc   = 0;
    seq  = 0;
    repeat (n) cycle();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Single host write, idle copper
    run(4, 6);

    // Copper streaming with one queued host write
    do_reset();
    cop_cnt   = 0;
    stall_cnt = 0;
    prev_lvl  = 0;
    host_seen = 0;
    run(1, 16);
    check_val("t35_cop_grants", cop_cnt, MaxBurst);
    check_val("t35_stall_cycles", stall_cnt, 1);
    check_val("t35_host_issued", host_seen, 1);

    // VRAM busy with both sides requesting
    do_reset();
    first_seen = 0;
    first_addr = '0;
    run(2, 10);
    check_val("t36_first_write_cop", first_addr, 3);

    // Full FIFO, then drain while a request is held
    do_reset();
    run(3, 30);

    // Reset with three entries queued, then idle
    do_reset();
    run(5, 8);
    check_val("t38_queued", fifo_level, 3);
    do_reset();
    run(6, 6);

    // Random traffic at several densities
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin p_host = 50; p_cop = 50; p_vram = 20; end
        1: begin p_host = 90; p_cop = 90; p_vram = 0;  end
        2: begin p_host = 80; p_cop = 20; p_vram = 10; end
        default: begin p_host = 30; p_cop = 95; p_vram = 30; end
      endcase
      do_reset();
      run(0, 300);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
